mem_access_unit: RTL and testbench

Data-memory access stage of the five-stage RISC-V pipeline, between the EX/MEM register and the MEM/WB register. It turns EX/MEM control and operands into a request/acknowledge transaction on the data-memory bus and handles RV32I byte-lane alignment and load sign/zero extension. It stalls the upstream pipeline while a transaction is outstanding and presents the finished load data on `RDdata_o` to the MEM/WB register.

---
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// RV32I data-memory access stage: request/acknowledge bus sequencing, byte-lane alignment, load extension.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses and add the misalign_o port.
`timescale 1ns/1ps
module mem_access_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RS2data_i,
  output logic        stall_o,
  output logic [31:0] RDdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t      state_r;
  logic        req_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  be_r;
  logic [31:0] rd_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic        access_s;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  store_be = 4'b0001 << off;
      3'b001:  store_be = 4'b0011 << {off[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  store_wdata = {4{d[7:0]}};
      3'b001:  store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  // Halfword selection uses only off[1], so a stray addr[0] is ignored when not trapping.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'h000000, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'h0000, h};
      default: load_ext = w;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_r;
  logic misalign_s;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: is_misaligned = 1'b0;
      3'b001, 3'b101: is_misaligned = off[0];
      default:        is_misaligned = (off != 2'b00);
    endcase
  endfunction

  assign misalign_s = is_misaligned(funct3_i, ALUResult_i[1:0]);
  assign misalign_o = misalign_r;
`endif

  assign access_s    = MemRead_i | MemWrite_i;
  assign mem_req_o   = req_r;
  assign mem_we_o    = we_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign mem_be_o    = be_r;
  assign RDdata_o    = rd_r;

  // Stall the upstream pipeline while an access is being issued or is outstanding.
  always_comb begin
    stall_o = 1'b0;
    if (rst_i) begin
      stall_o = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: stall_o = access_s;
        ST_WAIT: stall_o = 1'b1;
        default: stall_o = 1'b0;
      endcase
    end
  end

  // Transaction sequencer: latch the request, hold the bus until ack, capture load data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      be_r       <= 4'b0000;
      rd_r       <= 32'h0000_0000;
      f3_r       <= 3'b000;
      off_r      <= 2'b00;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (access_s) begin
            addr_r  <= {ALUResult_i[31:2], 2'b00};
            be_r    <= store_be(funct3_i, ALUResult_i[1:0]);
            wdata_r <= store_wdata(funct3_i, RS2data_i);
            f3_r    <= funct3_i;
            off_r   <= ALUResult_i[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
            if (misalign_s) begin
              misalign_r <= 1'b1;
              rd_r       <= 32'h0000_0000;
              state_r    <= ST_DONE;
            end else begin
              req_r   <= 1'b1;
              we_r    <= MemWrite_i;
              state_r <= ST_WAIT;
            end
`else
            req_r   <= 1'b1;
            we_r    <= MemWrite_i;
            state_r <= ST_WAIT;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (mem_ack_i) begin
            if (!we_r) begin
              rd_r <= load_ext(f3_r, off_r, mem_rdata_i);
            end
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_r <= 1'b0;
`endif
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, corner sequences, randomized model check.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] ALUResult_i, RS2data_i;
  logic        stall_o;
  logic [31:0] RDdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;

  mem_access_unit dut (
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o (misalign_o),
`endif
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .funct3_i    (funct3_i),
    .ALUResult_i (ALUResult_i),
    .RS2data_i   (RS2data_i),
    .stall_o     (stall_o),
    .RDdata_o    (RDdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdv;
    int          dly, exp_stall, exp_req;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic        be_chk;
    logic [31:0] exp_wd;
    logic        wd_chk, exp_mis, noise;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, input logic [2:0] f3,
                              input logic [31:0] addr, wd, rdv, input int dly, st, rq,
                              input logic [31:0] erd, input logic [3:0] ebe, input logic bec,
                              input logic [31:0] ewd, input logic wdc);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdv = rdv;
    v.dly = dly; v.exp_stall = st; v.exp_req = rq; v.exp_rd = erd;
    v.exp_be = ebe; v.be_chk = bec; v.exp_wd = ewd; v.wd_chk = wdc;
    v.exp_mis = 1'b0; v.noise = 1'b0;
    return v;
  endfunction

  // Reference model, from the lane/extension rules using plain arithmetic.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] o, v;
    o = a % 4;
    case (f3)
      3'd0: begin v = (w >> (8 * o)) & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'd4: v = (w >> (8 * o)) & 32'hFF;
      3'd1: begin v = (w >> (16 * (o / 2))) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd5: v = (w >> (16 * (o / 2))) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] o;
    o = a % 4;
    if (f3 == 3'd0)      return 4'(32'd1 << o);
    else if (f3 == 3'd1) return 4'(32'd3 << (2 * (o / 2)));
    else                 return 4'd15;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0)      return (d & 32'hFF) * 32'h01010101;
    else if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
    else                 return d;
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd0 || f3 == 3'd4)      return 1'b0;
    else if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) != 0;
    else                               return (a % 4) != 0;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_access(input vec_t v, input string tag);
    int  stalls, reqs;
    bit  done;
    MemRead_i = v.rd; MemWrite_i = v.wr; funct3_i = v.f3;
    ALUResult_i = v.addr; RS2data_i = v.wd; mem_rdata_i = v.rdv; mem_ack_i = 1'b0;
    stalls = 0; reqs = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #4;
      if (mem_req_o) begin
        check({tag, " addr"}, mem_addr_o, v.addr - (v.addr % 4));
        check({tag, " we"}, {31'd0, mem_we_o}, {31'd0, v.wr});
        if (v.be_chk) check({tag, " be"}, {28'd0, mem_be_o}, {28'd0, v.exp_be});
        if (v.wd_chk) check({tag, " wdata"}, mem_wdata_o, v.exp_wd);
        mem_ack_i = (reqs == v.dly);
        reqs++;
      end else begin
        mem_ack_i = v.noise;
      end
      if (stall_o) begin
        stalls++;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
      end else begin
        done = 1;
      end
    end
    mem_ack_i = 1'b0;
    if (!done) check({tag, " timeout"}, 32'd1, 32'd0);
    check({tag, " stall cycles"}, 32'(stalls), 32'(v.exp_stall));
    check({tag, " req cycles"}, 32'(reqs), 32'(v.exp_req));
    check({tag, " RDdata"}, RDdata_o, v.exp_rd);
    check({tag, " req after"}, {31'd0, mem_req_o}, 32'd0);
    check({tag, " we after"}, {31'd0, mem_we_o}, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    check({tag, " misalign"}, {31'd0, misalign_o}, {31'd0, v.exp_mis});
`endif
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  vec_t tbl[10];
  vec_t v;
  logic [31:0] rd_model;

  initial begin
    tbl[0] = mk(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'h0, 4'hF, 1, 32'hDEADBEEF, 1);
    tbl[1] = mk(1, 0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0, 2, 1, 32'hFFFFFF80, 4'b1000, 1, 32'h0, 0);
    tbl[2] = mk(1, 0, 3'b101, 32'h202, 32'h0, 32'hBEEF1234, 0, 2, 1, 32'h0000BEEF, 4'h0, 0, 32'h0, 0);
    tbl[3] = mk(1, 0, 3'b010, 32'h300, 32'h0, 32'h12345678, 3, 5, 4, 32'h12345678, 4'hF, 1, 32'h0, 0);
    tbl[4] = mk(0, 1, 3'b000, 32'h401, 32'h000000A5, 32'h0, 1, 3, 2, 32'h12345678, 4'b0010, 1, 32'hA5A5A5A5, 1);
    tbl[5] = mk(0, 1, 3'b001, 32'h402, 32'h0000CAFE, 32'h0, 0, 2, 1, 32'h12345678, 4'b1100, 1, 32'hCAFECAFE, 1);
    tbl[6] = mk(1, 0, 3'b001, 32'h500, 32'h0, 32'h00018001, 0, 2, 1, 32'hFFFF8001, 4'b0011, 1, 32'h0, 0);
    tbl[7] = mk(1, 1, 3'b010, 32'h600, 32'h11112222, 32'hFFFFFFFF, 1, 3, 2, 32'hFFFF8001, 4'hF, 1, 32'h11112222, 1);
    tbl[8] = mk(0, 0, 3'b010, 32'h700, 32'h0, 32'h0, 0, 0, 0, 32'hFFFF8001, 4'h0, 0, 32'h0, 0);
    tbl[9] = mk(1, 0, 3'b100, 32'h701, 32'h0, 32'h0000F000, 0, 2, 1, 32'h000000F0, 4'h0, 0, 32'h0, 0);

    // Reset state, with a pending load to show stall stays low during reset.
    rst_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; funct3_i = 3'b010;
    ALUResult_i = 32'h0; RS2data_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    #2;
    check("rst stall", {31'd0, stall_o}, 32'd0);
    check("rst req", {31'd0, mem_req_o}, 32'd0);
    check("rst we", {31'd0, mem_we_o}, 32'd0);
    check("rst addr", mem_addr_o, 32'd0);
    check("rst wdata", mem_wdata_o, 32'd0);
    check("rst be", {28'd0, mem_be_o}, 32'd0);
    check("rst RDdata", RDdata_o, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("rst misalign", {31'd0, misalign_o}, 32'd0);
`endif
    @(posedge clk_i); #1;
    MemRead_i = 1'b0; rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < 10; i++) run_access(tbl[i], $sformatf("vec%0d", i));

    // Misaligned word load.
`ifdef MEM_MISALIGN_TRAP_EN
    v = mk(1, 0, 3'b010, 32'h102, 32'h0, 32'hA5A50000, 0, 1, 0, 32'h0, 4'h0, 0, 32'h0, 0);
    v.exp_mis = 1'b1;
`else
    v = mk(1, 0, 3'b010, 32'h102, 32'h0, 32'hA5A50000, 0, 2, 1, 32'hA5A50000, 4'hF, 1, 32'h0, 0);
`endif
    run_access(v, "misalign word");

    // Reset in the middle of WAIT, then a late ack.
    MemRead_i = 1'b1; funct3_i = 3'b010; ALUResult_i = 32'h800;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("midrst req before", {31'd0, mem_req_o}, 32'd1);
    #3 rst_i = 1'b1;
    #1;
    check("midrst req async", {31'd0, mem_req_o}, 32'd0);
    check("midrst stall", {31'd0, stall_o}, 32'd0);
    MemRead_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    #3;
    check("late ack RDdata", RDdata_o, 32'd0);
    check("late ack req", {31'd0, mem_req_o}, 32'd0);
    check("late ack stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    run_access(mk(1, 0, 3'b010, 32'h900, 32'h0, 32'hCAFEF00D, 0, 2, 1, 32'hCAFEF00D, 4'hF, 1, 32'h0, 0),
               "post-reset load");
    rd_model = 32'hCAFEF00D;

    // Randomized accesses against the reference model.
    for (int n = 0; n < 150; n++) begin
      v.rd = 1'($urandom_range(0, 1)); v.wr = 1'($urandom_range(0, 1));
      v.f3 = 3'($urandom); v.addr = $urandom; v.wd = $urandom; v.rdv = $urandom;
      v.dly = int'($urandom_range(0, 3)); v.noise = 1'($urandom_range(0, 1));
      v.exp_be = m_be(v.f3, v.addr); v.exp_wd = m_wd(v.f3, v.wd);
      v.wd_chk = v.wr; v.be_chk = v.wr | (v.f3 == 3'd0) | (v.f3 == 3'd1);
      v.exp_mis = 1'b0;
      if (!(v.rd | v.wr)) begin
        v.exp_stall = 0; v.exp_req = 0;
      end else if (TRAP && m_mis(v.f3, v.addr)) begin
        v.exp_stall = 1; v.exp_req = 0; v.exp_mis = 1'b1; rd_model = 32'h0;
      end else begin
        v.exp_stall = 2 + v.dly; v.exp_req = 1 + v.dly;
        if (!v.wr) rd_model = m_load(v.f3, v.addr, v.rdv);
      end
      v.exp_rd = rd_model;
      run_access(v, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
